// File: rtl/timer_job_scheduler.sv
// Round-robin front end that lets N_REQ requesters share one serial-programmed timer.
// Each job sends pattern 1101 plus a latched delay nibble, waits for the timer, acks it, and reports completion.
module timer_job_scheduler #(
  parameter int N_REQ    = 4,
  parameter int START_TO = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] req_delay,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic [N_REQ-1:0]   job_done,
  output logic               job_err,
  output logic               tmr_data,
  output logic               tmr_ack,
  input  logic               tmr_counting,
  input  logic               tmr_done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = ($clog2(START_TO) > 2) ? $clog2(START_TO) : 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND_PAT  = 3'd1,
    S_SEND_DLY  = 3'd2,
    S_WAIT_CNT  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_ACK       = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Bits still to be sent after the current one: remaining pattern bits, then the latched delay.
  logic [6:0]       stream_q, stream_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] job_done_q, job_done_d;
  logic             busy_q, busy_d;
  logic             job_err_q, job_err_d;
  logic             tmr_data_q, tmr_data_d;
  logic             tmr_ack_q, tmr_ack_d;

  logic             found_s;
  logic [PW-1:0]    win_s;
  logic [PW:0]      sum_s;
  logic [3:0]       win_delay_s;

  // Round-robin search starting at the pointer, wrapping at N_REQ.
  always_comb begin
    found_s     = 1'b0;
    win_s       = '0;
    sum_s       = '0;
    win_delay_s = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum_s >= (PW+1)'(N_REQ)) begin
        sum_s = sum_s - (PW+1)'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      if (!found_s && req[sum_s[PW-1:0]]) begin
        found_s = 1'b1;
        win_s   = sum_s[PW-1:0];
      end else begin
        found_s = found_s;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (win_s == PW'(k)) begin
        win_delay_s = req_delay[4*k +: 4];
      end else begin
        win_delay_s = win_delay_s;
      end
    end
  end

  // Next-state and next-output logic; every output is the registered copy of its _d.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    stream_d   = stream_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    job_done_d = '0;
    job_err_d  = 1'b0;
    tmr_data_d = 1'b0;
    tmr_ack_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d    = S_SEND_PAT;
          cnt_d      = '0;
          grant_d    = '0;
          grant_d[win_s] = 1'b1;
          busy_d     = 1'b1;
          tmr_data_d = 1'b1;
          stream_d   = {3'b101, win_delay_s};
          if (win_s == PW'(N_REQ-1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = win_s + PW'(1);
          end
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      S_SEND_PAT: begin
        tmr_data_d = stream_q[6];
        stream_d   = {stream_q[5:0], 1'b0};
        if (cnt_q == CW'(3)) begin
          state_d = S_SEND_DLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SEND_DLY: begin
        stream_d = {stream_q[5:0], 1'b0};
        if (cnt_q == CW'(3)) begin
          state_d    = S_WAIT_CNT;
          cnt_d      = '0;
          tmr_data_d = 1'b0;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          tmr_data_d = stream_q[6];
        end
      end
      S_WAIT_CNT: begin
        // A done seen here means counting was missed, not that the timer failed.
        if (tmr_done) begin
          state_d    = S_ACK;
          tmr_ack_d  = 1'b1;
          job_done_d = grant_q;
        end else if (tmr_counting) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(START_TO-1)) begin
          state_d    = S_ACK;
          tmr_ack_d  = 1'b1;
          job_done_d = grant_q;
          job_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (tmr_done) begin
          state_d    = S_ACK;
          tmr_ack_d  = 1'b1;
          job_done_d = grant_q;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      stream_q   <= 7'd0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      job_done_q <= '0;
      job_err_q  <= 1'b0;
      tmr_data_q <= 1'b0;
      tmr_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      stream_q   <= stream_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      job_done_q <= job_done_d;
      job_err_q  <= job_err_d;
      tmr_data_q <= tmr_data_d;
      tmr_ack_q  <= tmr_ack_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign job_done = job_done_q;
  assign job_err  = job_err_q;
  assign tmr_data = tmr_data_q;
  assign tmr_ack  = tmr_ack_q;

endmodule

// File: tb/tb_timer_job_scheduler.sv
// Directed bench for timer_job_scheduler: a job table run back to back plus reset and idle sequences.
module tb_timer_job_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'd0;
  logic [15:0] req_delay = 16'd0;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  job_done;
  logic        job_err;
  logic        tmr_data;
  logic        tmr_ack;
  logic        tmr_counting = 1'b0;
  logic        tmr_done = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  // mode: 0 = timer counts then finishes, 1 = timer never counts, 2 = done without counting
  typedef struct {
    logic [3:0]  req;
    logic [15:0] dly;
    int          mode;
    logic        mut;
    logic [3:0]  grant;
    logic [7:0]  stream;
    logic        err;
    int          ack_c;
  } vec_t;

  vec_t vecs[10];
  vec_t hv;

  timer_job_scheduler #(.N_REQ(4), .START_TO(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_delay(req_delay),
    .grant(grant), .busy(busy), .job_done(job_done), .job_err(job_err),
    .tmr_data(tmr_data), .tmr_ack(tmr_ack),
    .tmr_counting(tmr_counting), .tmr_done(tmr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else n_pass++;
  endtask

  // Called from an IDLE cycle; the first negedge inside lands on T+1.
  task automatic run_job(input vec_t v);
    logic [7:0] got;
    bit onehot_ok;
    int ack_at;
    int pulses;
    got = 8'd0; onehot_ok = 1'b1; ack_at = -1; pulses = 0;
    req = v.req; req_delay = v.dly;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      got[i] = tmr_data;
      if ($countones(grant) != 1) onehot_ok = 1'b0;
      if (job_done != 4'd0) pulses++;
      if (i == 7) begin
        chk("grant", 32'(grant), 32'(v.grant));
        chk("busy_on_grant", 32'(busy), 32'd1);
      end
      if (v.mut && i == 6) req_delay = ~req_delay;
      if (v.mut && i == 5) req = 4'd0;
    end
    chk("stream", 32'(got), 32'(v.stream));
    for (int c = 1; c <= 200 && ack_at < 0; c++) begin
      @(negedge clk);
      if (job_done != 4'd0) pulses++;
      if (tmr_ack) begin
        ack_at = c;
        chk("job_done", 32'(job_done), 32'(v.grant));
        chk("job_err", 32'(job_err), 32'(v.err));
      end else begin
        if ($countones(grant) != 1) onehot_ok = 1'b0;
        if (tmr_data !== 1'b0) onehot_ok = 1'b0;
        case (v.mode)
          0: begin tmr_counting = 1'b1; tmr_done = (c == 5); end
          2: tmr_done = (c == 2);
          default: begin tmr_counting = 1'b0; tmr_done = 1'b0; end
        endcase
      end
    end
    tmr_counting = 1'b0; tmr_done = 1'b0;
    chk("ack_latency", 32'(ack_at), 32'(v.ack_c));
    @(negedge clk);
    if (job_done != 4'd0) pulses++;
    chk("back_to_idle", {26'd0, tmr_ack, busy, grant}, 32'd0);
    chk("done_pulses", 32'(pulses), 32'd1);
    chk("onehot_quiet", 32'(onehot_ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0001, 16'h0002, 0, 1'b0, 4'b0001, 8'hD2, 1'b0, 6};
    vecs[1] = '{4'b1010, 16'h3010, 0, 1'b0, 4'b0010, 8'hD1, 1'b0, 6};
    vecs[2] = '{4'b1010, 16'h3010, 0, 1'b0, 4'b1000, 8'hD3, 1'b0, 6};
    vecs[3] = '{4'b1010, 16'h3010, 0, 1'b0, 4'b0010, 8'hD1, 1'b0, 6};
    vecs[4] = '{4'b1010, 16'h3010, 0, 1'b0, 4'b1000, 8'hD3, 1'b0, 6};
    vecs[5] = '{4'b0001, 16'h0000, 1, 1'b0, 4'b0001, 8'hD0, 1'b1, 5};
    vecs[6] = '{4'b0100, 16'h0F00, 2, 1'b0, 4'b0100, 8'hDF, 1'b0, 3};
    vecs[7] = '{4'b1111, 16'h4321, 0, 1'b0, 4'b1000, 8'hD4, 1'b0, 6};
    vecs[8] = '{4'b1111, 16'h4321, 0, 1'b0, 4'b0001, 8'hD1, 1'b0, 6};
    vecs[9] = '{4'b0001, 16'h000F, 0, 1'b1, 4'b0001, 8'hDF, 1'b0, 6};

    repeat (3) @(negedge clk);
    chk("reset_state", {22'd0, grant, busy, job_done, job_err, tmr_data, tmr_ack}, 32'd0);
    reset = 1'b0;

    for (int n = 0; n < 10; n++) run_job(vecs[n]);

    // Reset in the middle of SEND_DLY aborts the job at once.
    req = 4'b0001; req_delay = 16'h0006;
    repeat (6) @(negedge clk);
    chk("midjob_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset", {22'd0, grant, busy, job_done, job_err, tmr_data, tmr_ack}, 32'd0);
    @(negedge clk);
    chk("reset_held", {22'd0, grant, busy, job_done, job_err, tmr_data, tmr_ack}, 32'd0);
    reset = 1'b0; req = 4'd0;
    hv = '{4'b1000, 16'h5000, 0, 1'b0, 4'b1000, 8'hD5, 1'b0, 6};
    run_job(hv);

    // Pointer restarts at 0 after reset, so req1 wins over req3.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hv = '{4'b1010, 16'h3010, 0, 1'b0, 4'b0010, 8'hD1, 1'b0, 6};
    run_job(hv);

    begin
      bit quiet;
      quiet = 1'b1;
      req = 4'd0;
      repeat (100) begin
        @(negedge clk);
        if (tmr_data !== 1'b0 || busy !== 1'b0 || grant !== 4'd0) quiet = 1'b0;
      end
      chk("idle_quiet", 32'(quiet), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
